// File: rtl/shift_register_tx_arbiter.sv
// Round-robin arbiter sharing one PISO shift register between requesters A and B; grant->LOAD next cycle,
// then WIDTH shift strobes every CLK_DIV clocks; requests are only sampled in IDLE and wait while busy.
module shift_register_tx_arbiter #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic [WIDTH-1:0] din_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] din_b,
    output logic             ack_a,
    output logic             ack_b,
    output logic [WIDTH-1:0] sr_pin,
    output logic             sr_ps,
    output logic             sr_en,
    output logic             busy,
    output logic             done,
    output logic             owner
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [DW-1:0]    div_cnt, div_nxt;
    logic [BW-1:0]    bit_cnt, bit_nxt;
    logic [WIDTH-1:0] pin_q, pin_nxt;
    logic             owner_q, owner_nxt;
    logic             last_owner, last_nxt;
    logic             winner;
    logic             div_wrap;

    // On a tie the requester not served last wins; otherwise whoever is asking.
    assign winner   = (req_a && req_b) ? ~last_owner : req_b;
    assign div_wrap = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            pin_q      <= '0;
            owner_q    <= 1'b0;
            last_owner <= 1'b1;
        end else begin
            state      <= state_nxt;
            div_cnt    <= div_nxt;
            bit_cnt    <= bit_nxt;
            pin_q      <= pin_nxt;
            owner_q    <= owner_nxt;
            last_owner <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        div_nxt   = div_cnt;
        bit_nxt   = bit_cnt;
        pin_nxt   = pin_q;
        owner_nxt = owner_q;
        last_nxt  = last_owner;
        case (state)
            IDLE: begin
                if (req_a || req_b) begin
                    state_nxt = LOAD;
                    owner_nxt = winner;
                    pin_nxt   = winner ? din_b : din_a;
                end
            end
            LOAD: begin
                div_nxt   = '0;
                bit_nxt   = '0;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                if (div_wrap) begin
                    div_nxt = '0;
                    bit_nxt = bit_cnt + BW'(1);
                    if (bit_cnt == BIT_LAST) begin
                        state_nxt = DONE;
                    end
                end else begin
                    div_nxt = div_cnt + DW'(1);
                end
            end
            DONE: begin
                last_nxt  = owner_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Every output decodes from registered state, so no input reaches an output combinationally.
    assign sr_pin = pin_q;
    assign owner  = owner_q;
    assign sr_ps  = (state == LOAD);
    assign sr_en  = (state == LOAD) || ((state == SHIFT) && div_wrap);
    assign ack_a  = (state == LOAD) && !owner_q;
    assign ack_b  = (state == LOAD) && owner_q;
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

endmodule
